// File: rtl/mips_fetch_unit.sv
// mips_fetch_unit: instruction fetch stage of the 16-bit MIPS datapath.
// Owns the word-addressed PC, drives the combinational instruction memory,
// and fills the IF/ID pipeline register. It handles decode stalls and
// branch/jump redirects.
// Optional feature: define FETCH_HALT_DETECT_EN to stop fetching on HALT_INSTR.
module mips_fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter logic [15:0] NOP_INSTR  = 16'h0000,
  parameter logic [15:0] HALT_INSTR = 16'hFFFF
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] pc_o,
  input  logic [15:0] instr_i,
  input  logic        stall_i,
  input  logic        branch_taken_i,
  input  logic [31:0] branch_target_i,
  output logic [15:0] if_id_instr_o,
  output logic [31:0] if_id_pc_o,
  output logic        if_id_valid_o,
  output logic        halt_o
);

  typedef enum logic [1:0] {
    BOOT   = 2'd0,
    RUN    = 2'd1,
    HALTED = 2'd2
  } state_t;

`ifdef FETCH_HALT_DETECT_EN
  localparam bit HALT_EN = 1'b1;
`else
  localparam bit HALT_EN = 1'b0;
`endif

  state_t      state, state_d;
  logic [31:0] pc_d;
  logic [15:0] instr_d;
  logic [31:0] ipc_d;
  logic        valid_d;

  // State and pipeline registers; reset loads the boot PC and a NOP bubble.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= BOOT;
      pc_o          <= RESET_PC;
      if_id_instr_o <= NOP_INSTR;
      if_id_pc_o    <= '0;
      if_id_valid_o <= 1'b0;
    end else begin
      state         <= state_d;
      pc_o          <= pc_d;
      if_id_instr_o <= instr_d;
      if_id_pc_o    <= ipc_d;
      if_id_valid_o <= valid_d;
    end
  end

  // Next-state and next-register selection: redirect beats stall beats capture.
  always_comb begin
    state_d = state;
    pc_d    = pc_o;
    instr_d = if_id_instr_o;
    ipc_d   = if_id_pc_o;
    valid_d = if_id_valid_o;
    case (state)
      BOOT: begin
        state_d = RUN;
      end
      RUN: begin
        if (branch_taken_i) begin
          pc_d    = branch_target_i;
          instr_d = NOP_INSTR;
          valid_d = 1'b0;
        end else if (!stall_i) begin
          instr_d = instr_i;
          ipc_d   = pc_o;
          valid_d = 1'b1;
          // A captured halt parks the PC on its own address.
          if (HALT_EN && (instr_i == HALT_INSTR)) state_d = HALTED;
          else                                    pc_d    = pc_o + 32'd1;
        end
      end
      HALTED: begin
        if (branch_taken_i) begin
          pc_d    = branch_target_i;
          instr_d = NOP_INSTR;
          valid_d = 1'b0;
          state_d = RUN;
        end else if (!stall_i) begin
          instr_d = NOP_INSTR;
          valid_d = 1'b0;
        end
      end
      default: begin
        state_d = BOOT;
      end
    endcase
  end

  // halt_o is a decode of the registered state, so it stays glitch-free.
`ifdef FETCH_HALT_DETECT_EN
  assign halt_o = (state == HALTED);
`else
  assign halt_o = 1'b0;
`endif

endmodule
